conv_enc_framer: RTL and testbench
==================================

Name: conv_enc_framer

Overview:
- Parametrised rate-1/2 convolutional encoder and framer.
- Builds the 2*DATA_W-bit symbol packets that the Viterbi system consumes on its data_i/dvalid_i/busy_o interface.
- Adds what the current packet path lacks: generic word width and generator polynomials, valid/ready input with busy backpressure, per-word error-mask injection for BIST, and automatic zero-tail flush/termination at frame end.

Parameters:
- DATA_W, 8: input bits per word; output word is 2*DATA_W symbols.
- K, 3: constraint length; encoder state is K-1 bits.
- G1, 3'b111: generator for upper symbol bit; bit K-1 taps current input, bit K-2 the most recent past bit, bit 0 the oldest.
- G0, 3'b101: generator for lower symbol bit; same tap ordering as G1.
- FLUSH_WORDS, 2: zero-input words emitted after a terminated frame (covers TBL=15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  block accepts a word this cycle.
- data_i  in  DATA_W  input bits, MSB encoded first.
- last_i  in  1  last word of frame; used only when term_mode_i=1.
- term_mode_i  in  1  0 = continuous stream, 1 = zero-tail termination; sampled with each accepted word.
- err_mask_i  in  2*DATA_W  XOR mask applied to this word's symbols; sampled on accept.
- enc_data_o  out  2*DATA_W  encoded packet.
- enc_valid_o  out  1  enc_data_o holds a packet.
- dec_busy_i  in  1  downstream busy; packet transfers when enc_valid_o && !dec_busy_i.
- flushing_o  out  1  high while tail words are being emitted.

Behaviour:
- Reset (rst_n=0 at posedge):
  - enc_valid_o=0, enc_data_o=0, flushing_o=0, in_ready_o=0 during reset.
  - Encoder state=0, flush counter=0, FSM=IDLE.
  - Applies mid-frame or mid-flush with no residual output.
- Encoding, per bit u, MSB-first:
  - For i=DATA_W-1 down to 0, with state s={s1,s0} (s1 most recent):
    - sym1 = parity(G1 & {u,s}), sym0 = parity(G0 & {u,s}).
    - Next state = {u, s[K-2:1]}.
  - sym1 is placed at bit 2i+1, sym0 at bit 2i.
  - The whole word is unrolled combinationally and completes in one cycle.
  - The mask is XORed after encoding. The mask never affects encoder state.
- Latency: word accepted at edge N gives enc_valid_o=1 after edge N, i.e. visible in cycle N+1.
- Output register:
  - Holds enc_data_o and enc_valid_o stable while dec_busy_i=1.
  - Clears enc_valid_o after transfer unless a new packet is loaded in the same cycle.
- in_ready_o = (FSM==IDLE) && (!enc_valid_o || !dec_busy_i). This allows back-to-back words at one per cycle when downstream is not busy.
- FSM:
  - IDLE: on accept with last_i && term_mode_i, go to FLUSH with counter=FLUSH_WORDS. Otherwise stay in IDLE; encoder state carries across words.
  - FLUSH:
    - flushing_o=1, in_ready_o=0.
    - Each time the output slot is free, load the encoding of an all-zero word, mask forced to 0, and decrement the counter.
    - When the counter reaches 0 and that last word is loaded, go to IDLE; encoder state is then 0 provided FLUSH_WORDS*DATA_W >= K-1.
- Continuous mode: last_i is ignored and no flush occurs. Encoder state never resets except by rst_n.
- Simultaneous load and transfer in one cycle: the new packet replaces the old one, and enc_valid_o stays 1.
- in_valid_i with in_ready_o=0: the word is not consumed; upstream holds it.
- dec_busy_i held high indefinitely: the output is held with no loss; FLUSH pauses.

Test Plan:
- Reset, then send 0xA5 with mask 0x0000, continuous mode, dec_busy_i=0 -> enc_data_o=0xE2F8 one cycle after accept; final encoder state {1,0}.
- Next word 0x3C with mask 0x0001 -> enc_data_o=0xBDA6 (unmasked 0xBDA7); end state 0.
- Term mode: send 0xA5 with last_i=1 from reset -> packets 0xE2F8, 0xB000, 0x0000; flushing_o high across the two tail words; in_ready_o=0 until return to IDLE.
- Hold dec_busy_i=1 for 5 cycles while a packet is valid -> enc_data_o stable, in_ready_o=0, no words lost; stream resumes at one per cycle after release.
- Assert rst_n=0 during FLUSH after the first tail word -> next cycle enc_valid_o=0, flushing_o=0; next 0xA5 encodes as 0xE2F8 (state cleared).
- Back-to-back 10 random words with random busy, against a reference encoder model -> every packet matches in order, none dropped or duplicated.

Source files
------------

// File: rtl/conv_enc_framer.sv
// Rate-1/2 convolutional encoder and packet framer. Each accepted word is encoded in
// one cycle, optionally masked, and followed by zero-tail words when a frame is terminated.
module conv_enc_framer #(
    parameter int           DATA_W      = 8,
    parameter int           K           = 3,
    parameter logic [K-1:0] G1          = 3'b111,
    parameter logic [K-1:0] G0          = 3'b101,
    parameter int           FLUSH_WORDS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  last_i,
    input  logic                  term_mode_i,
    input  logic [2*DATA_W-1:0]   err_mask_i,
    output logic [2*DATA_W-1:0]   enc_data_o,
    output logic                  enc_valid_o,
    input  logic                  dec_busy_i,
    output logic                  flushing_o
);

    localparam int CNT_W = (FLUSH_WORDS > 0) ? $clog2(FLUSH_WORDS + 1) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt_reg;
    logic [CNT_W-1:0]    cnt_next;
    logic [K-2:0]        enc_state_reg;
    logic [2*DATA_W-1:0] enc_data_reg;
    logic                enc_valid_reg;

    logic                out_free;
    logic                accept;
    logic                load;
    logic [DATA_W-1:0]   enc_in;
    logic [2*DATA_W-1:0] mask;
    logic [2*DATA_W-1:0] sym;
    logic [K-2:0]        enc_state_next;

    // Output slot is free when empty or when its packet leaves this cycle.
    assign out_free    = !enc_valid_reg || !dec_busy_i;
    assign in_ready_o  = rst_n && (state_reg == IDLE) && out_free;
    assign accept      = in_valid_i && in_ready_o;
    assign flushing_o  = rst_n && (state_reg == FLUSH);
    assign enc_data_o  = enc_data_reg;
    assign enc_valid_o = enc_valid_reg;

    // Unrolled trellis: stage gi encodes bit DATA_W-1-gi, so the MSB goes first.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bit
            localparam int BI = DATA_W - 1 - gi;
            logic [K-2:0] st_in;
            logic [K-2:0] st_out;
            logic [K-1:0] taps;

            if (gi == 0) begin : g_first
                assign st_in = enc_state_reg;
            end else begin : g_chain
                assign st_in = g_bit[gi-1].st_out;
            end

            assign taps          = {enc_in[BI], st_in};
            assign sym[2*BI+1]   = ^(G1 & taps);
            assign sym[2*BI]     = ^(G0 & taps);
            assign st_out        = taps[K-1:1];
        end
    endgenerate

    assign enc_state_next = g_bit[DATA_W-1].st_out;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load       = 1'b0;
        enc_in     = data_i;
        mask       = err_mask_i;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
                    if (last_i && term_mode_i && (FLUSH_WORDS > 0)) begin
                        state_next = FLUSH;
                        cnt_next   = CNT_W'(FLUSH_WORDS);
                    end
                end
            end
            FLUSH: begin
                // Tail words are unmasked zeros that drive the encoder back to state 0.
                enc_in = '0;
                mask   = '0;
                if (out_free) begin
                    load     = 1'b1;
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            enc_state_reg <= '0;
            enc_data_reg  <= '0;
            enc_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (load) begin
                enc_data_reg  <= sym ^ mask;
                enc_valid_reg <= 1'b1;
                enc_state_reg <= enc_state_next;
            end else if (!dec_busy_i) begin
                enc_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_enc_framer.sv
// Self-checking bench for conv_enc_framer: directed vectors plus a randomized stream
// compared against a bit-history reference encoder.
module tb_conv_enc_framer;

    localparam int           DW = 8;
    localparam int           K  = 3;
    localparam logic [K-1:0] G1 = 3'b111;
    localparam logic [K-1:0] G0 = 3'b101;
    localparam int           FW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] data_i = '0;
    logic          last_i = 1'b0;
    logic          term_mode_i = 1'b0;
    logic [2*DW-1:0] err_mask_i = '0;
    logic [2*DW-1:0] enc_data_o;
    logic          enc_valid_o;
    logic          dec_busy_i = 1'b0;
    logic          flushing_o;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference history: hist[0] is the most recent input bit.
    bit hist [K-1];

    always #5 clk = ~clk;

    conv_enc_framer #(
        .DATA_W(DW), .K(K), .G1(G1), .G0(G0), .FLUSH_WORDS(FW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .data_i(data_i),
        .last_i(last_i),
        .term_mode_i(term_mode_i),
        .err_mask_i(err_mask_i),
        .enc_data_o(enc_data_o),
        .enc_valid_o(enc_valid_o),
        .dec_busy_i(dec_busy_i),
        .flushing_o(flushing_o)
    );

    task automatic ref_reset();
        for (int j = 0; j < K-1; j++) hist[j] = 1'b0;
    endtask

    // Each symbol is the XOR of the generator-selected bits in the window
    // (current bit at delay 0, older bits at larger delays).
    task automatic ref_encode(input logic [DW-1:0] d, input logic [2*DW-1:0] m,
                              output logic [2*DW-1:0] p);
        bit w [K];
        bit s1;
        bit s0;
        p = '0;
        for (int i = DW-1; i >= 0; i--) begin
            w[0] = d[i];
            for (int j = 1; j < K; j++) w[j] = hist[j-1];
            s1 = 1'b0;
            s0 = 1'b0;
            for (int j = 0; j < K; j++) begin
                s1 = s1 ^ (G1[K-1-j] & w[j]);
                s0 = s0 ^ (G0[K-1-j] & w[j]);
            end
            p[2*i+1] = s1;
            p[2*i]   = s0;
            for (int j = K-2; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = d[i];
        end
        p = p ^ m;
    endtask

    // Drives one cycle of inputs and returns the outputs seen mid-cycle.
    task automatic drive_cycle(input logic v, input logic [DW-1:0] d, input logic l,
                               input logic t, input logic [2*DW-1:0] m, input logic b,
                               output logic rdy, output logic vld,
                               output logic [2*DW-1:0] dat, output logic fl);
        in_valid_i  = v;
        data_i      = d;
        last_i      = l;
        term_mode_i = t;
        err_mask_i  = m;
        dec_busy_i  = b;
        @(negedge clk);
        rdy = in_ready_o;
        vld = enc_valid_o;
        dat = enc_data_o;
        fl  = flushing_o;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        in_valid_i = 1'b0;
        dec_busy_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ref_reset();
    endtask

    task automatic test_reset();
        logic r, v, f;
        logic [2*DW-1:0] d;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1'b1, 8'hA5, 1'b1, 1'b1, 16'hFFFF, 1'b0, r, v, d, f);
            $display("reset cycle %0d: ready=%b valid=%b data=%h flushing=%b", c, r, v, d, f);
            n_compared += 4;
            if (r !== 1'b0) begin n_mismatched++; $display("FAIL reset_ready: got %b expected 0", r); end
            if (v !== 1'b0) begin n_mismatched++; $display("FAIL reset_valid: got %b expected 0", v); end
            if (d !== 16'h0000) begin n_mismatched++; $display("FAIL reset_data: got %h expected 0000", d); end
            if (f !== 1'b0) begin n_mismatched++; $display("FAIL reset_flushing: got %b expected 0", f); end
        end
        rst_n = 1'b1;
        ref_reset();
    endtask

    task automatic test_known_vectors();
        logic r, v, f;
        logic [2*DW-1:0] d;
        apply_reset();
        drive_cycle(1'b1, 8'hA5, 1'b0, 1'b0, 16'h0000, 1'b0, r, v, d, f);
        n_compared++;
        if (r !== 1'b1) begin n_mismatched++; $display("FAIL known_ready: got %b expected 1", r); end
        drive_cycle(1'b1, 8'h3C, 1'b0, 1'b0, 16'h0001, 1'b0, r, v, d, f);
        $display("known word A5: data=%h valid=%b", d, v);
        n_compared += 2;
        if (v !== 1'b1) begin n_mismatched++; $display("FAIL known_a5_valid: got %b expected 1", v); end
        if (d !== 16'hE2F8) begin n_mismatched++; $display("FAIL known_a5_data: got %h expected e2f8", d); end
        drive_cycle(1'b1, 8'hA5, 1'b0, 1'b0, 16'h0000, 1'b0, r, v, d, f);
        $display("known word 3C masked: data=%h", d);
        n_compared++;
        if (d !== 16'hBDA6) begin n_mismatched++; $display("FAIL known_3c_data: got %h expected bda6", d); end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, r, v, d, f);
        $display("known word A5 after 3C: data=%h", d);
        n_compared++;
        if (d !== 16'hE2F8) begin n_mismatched++; $display("FAIL known_state_zero: got %h expected e2f8", d); end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, r, v, d, f);
        n_compared++;
        if (v !== 1'b0) begin n_mismatched++; $display("FAIL known_drain_valid: got %b expected 0", v); end
    endtask

    task automatic test_term_flush();
        logic r, v, f;
        logic [2*DW-1:0] d;
        logic [2*DW-1:0] exp_tail [2];
        exp_tail[0] = 16'hE2F8;
        exp_tail[1] = 16'hB000;
        apply_reset();
        drive_cycle(1'b1, 8'hA5, 1'b1, 1'b1, 16'h0000, 1'b0, r, v, d, f);
        for (int c = 0; c < 2; c++) begin
            drive_cycle(1'b1, 8'hFF, 1'b1, 1'b1, 16'hFFFF, 1'b0, r, v, d, f);
            $display("flush cycle %0d: data=%h flushing=%b ready=%b", c, d, f, r);
            n_compared += 4;
            if (v !== 1'b1) begin n_mismatched++; $display("FAIL flush_valid: got %b expected 1", v); end
            if (d !== exp_tail[c]) begin n_mismatched++; $display("FAIL flush_data: got %h expected %h", d, exp_tail[c]); end
            if (f !== 1'b1) begin n_mismatched++; $display("FAIL flush_flag: got %b expected 1", f); end
            if (r !== 1'b0) begin n_mismatched++; $display("FAIL flush_ready: got %b expected 0", r); end
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, r, v, d, f);
        $display("flush end: data=%h flushing=%b ready=%b", d, f, r);
        n_compared += 4;
        if (v !== 1'b1) begin n_mismatched++; $display("FAIL flush_last_valid: got %b expected 1", v); end
        if (d !== 16'h0000) begin n_mismatched++; $display("FAIL flush_last_data: got %h expected 0000", d); end
        if (f !== 1'b0) begin n_mismatched++; $display("FAIL flush_end_flag: got %b expected 0", f); end
        if (r !== 1'b1) begin n_mismatched++; $display("FAIL flush_end_ready: got %b expected 1", r); end
        drive_cycle(1'b1, 8'hA5, 1'b0, 1'b0, 16'h0000, 1'b0, r, v, d, f);
        n_compared++;
        if (v !== 1'b0) begin n_mismatched++; $display("FAIL flush_idle_valid: got %b expected 0", v); end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, r, v, d, f);
        n_compared++;
        if (d !== 16'hE2F8) begin n_mismatched++; $display("FAIL flush_state_cleared: got %h expected e2f8", d); end
    endtask

    task automatic test_busy_hold();
        logic r, v, f;
        logic [2*DW-1:0] d;
        logic [DW-1:0] w1, w2, w3;
        logic [2*DW-1:0] m2, m3, e1, e2, e3;
        apply_reset();
        w1 = DW'($urandom);
        w2 = DW'($urandom);
        w3 = DW'($urandom);
        m2 = (2*DW)'($urandom);
        m3 = (2*DW)'($urandom);
        drive_cycle(1'b1, w1, 1'b0, 1'b0, 16'h0000, 1'b0, r, v, d, f);
        ref_encode(w1, 16'h0000, e1);
        for (int c = 0; c < 5; c++) begin
            drive_cycle(1'b1, w2, 1'b0, 1'b0, m2, 1'b1, r, v, d, f);
            $display("busy cycle %0d: data=%h valid=%b ready=%b", c, d, v, r);
            n_compared += 3;
            if (v !== 1'b1) begin n_mismatched++; $display("FAIL busy_valid: got %b expected 1", v); end
            if (d !== e1) begin n_mismatched++; $display("FAIL busy_data: got %h expected %h", d, e1); end
            if (r !== 1'b0) begin n_mismatched++; $display("FAIL busy_ready: got %b expected 0", r); end
        end
        drive_cycle(1'b1, w2, 1'b0, 1'b0, m2, 1'b0, r, v, d, f);
        ref_encode(w2, m2, e2);
        n_compared += 2;
        if (d !== e1) begin n_mismatched++; $display("FAIL busy_release_data: got %h expected %h", d, e1); end
        if (r !== 1'b1) begin n_mismatched++; $display("FAIL busy_release_ready: got %b expected 1", r); end
        drive_cycle(1'b1, w3, 1'b0, 1'b0, m3, 1'b0, r, v, d, f);
        ref_encode(w3, m3, e3);
        n_compared += 2;
        if (d !== e2) begin n_mismatched++; $display("FAIL busy_next_data: got %h expected %h", d, e2); end
        if (r !== 1'b1) begin n_mismatched++; $display("FAIL busy_next_ready: got %b expected 1", r); end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, r, v, d, f);
        $display("busy resume: data=%h valid=%b", d, v);
        n_compared += 2;
        if (v !== 1'b1) begin n_mismatched++; $display("FAIL busy_third_valid: got %b expected 1", v); end
        if (d !== e3) begin n_mismatched++; $display("FAIL busy_third_data: got %h expected %h", d, e3); end
    endtask

    task automatic test_reset_mid_flush();
        logic r, v, f;
        logic [2*DW-1:0] d;
        apply_reset();
        drive_cycle(1'b1, 8'hA5, 1'b1, 1'b1, 16'h0000, 1'b0, r, v, d, f);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, r, v, d, f);
        n_compared++;
        if (f !== 1'b1) begin n_mismatched++; $display("FAIL midflush_flag: got %b expected 1", f); end
        rst_n = 1'b0;
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, r, v, d, f);
        rst_n = 1'b1;
        drive_cycle(1'b1, 8'hA5, 1'b0, 1'b0, 16'h0000, 1'b0, r, v, d, f);
        $display("after mid-flush reset: valid=%b flushing=%b ready=%b", v, f, r);
        n_compared += 3;
        if (v !== 1'b0) begin n_mismatched++; $display("FAIL midflush_valid: got %b expected 0", v); end
        if (f !== 1'b0) begin n_mismatched++; $display("FAIL midflush_flushing: got %b expected 0", f); end
        if (r !== 1'b1) begin n_mismatched++; $display("FAIL midflush_ready: got %b expected 1", r); end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, r, v, d, f);
        n_compared++;
        if (d !== 16'hE2F8) begin n_mismatched++; $display("FAIL midflush_state_cleared: got %h expected e2f8", d); end
    endtask

    task automatic test_back_to_back();
        logic r, v, f;
        logic [2*DW-1:0] d;
        logic [2*DW-1:0] e;
        logic [2*DW-1:0] exp_q [$];
        logic have;
        logic [DW-1:0] pd;
        logic [2*DW-1:0] pm;
        logic pl, pt, dv, db;
        int sent, cyc, pkt;
        apply_reset();
        have = 1'b0;
        pd = '0; pm = '0; pl = 1'b0; pt = 1'b0;
        sent = 0; cyc = 0; pkt = 0;
        while ((sent < 10 || exp_q.size() > 0) && cyc < 400) begin
            if (!have && sent < 10) begin
                pd   = DW'($urandom);
                pm   = ($urandom_range(0, 1) == 0) ? 16'h0000 : (2*DW)'($urandom);
                pl   = ($urandom_range(0, 1) == 0);
                pt   = ($urandom_range(0, 2) == 0);
                have = 1'b1;
            end
            dv = have && ($urandom_range(0, 4) != 0);
            db = ($urandom_range(0, 3) == 0);
            drive_cycle(dv, pd, pl, pt, pm, db, r, v, d, f);
            cyc++;
            n_compared++;
            if (f && r) begin n_mismatched++; $display("FAIL b2b_ready_in_flush: got ready=1 expected 0"); end
            if (v && !db) begin
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_mismatched++;
                    $display("FAIL b2b_extra_packet: got %h expected none", d);
                end else begin
                    e = exp_q.pop_front();
                    $display("b2b packet %0d: got %h exp %h", pkt, d, e);
                    if (d !== e) begin n_mismatched++; $display("FAIL b2b_packet: got %h expected %h", d, e); end
                end
                pkt++;
            end
            if (dv && r) begin
                ref_encode(pd, pm, e);
                exp_q.push_back(e);
                if (pl && pt) begin
                    for (int t = 0; t < FW; t++) begin
                        ref_encode('0, '0, e);
                        exp_q.push_back(e);
                    end
                end
                sent++;
                have = 1'b0;
            end
        end
        n_compared++;
        if (cyc >= 400) begin
            n_mismatched++;
            $display("FAIL b2b_timeout: got %0d words sent, %0d packets pending, expected 10 sent and 0 pending", sent, exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_known_vectors();
        test_term_flush();
        test_busy_hold();
        test_reset_mid_flush();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
